memory_write_scheduler: RTL and testbench

//  Arbitrates write traffic from two sources, host bus and blitter, into MemoryManager's single write port.

---
 rtl/memory_write_scheduler_pkg.sv | 16 +
 rtl/memory_write_scheduler_if.sv | 36 +++
 rtl/memory_write_scheduler_fifo.sv | 43 ++++
 rtl/memory_write_scheduler.sv | 104 ++++++++++
 tb/tb_memory_write_scheduler.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/memory_write_scheduler_pkg.sv
// Shared types for the memory write scheduler: requester ids, queued write entry, issue FSM states.
package mem_sched_pkg;

  localparam int unsigned MEM_ADDR_W = 17;
  localparam int unsigned MEM_DATA_W = 8;

  typedef enum logic {REQ_HOST, REQ_BLIT} requester_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } write_entry_t;

  typedef enum logic [1:0] {ISSUE_IDLE, ISSUE_WAIT, ISSUE_GAP} issue_state_t;

endpackage

// File: rtl/memory_write_scheduler_if.sv
// Write-source and MemoryManager write-port signals; slave = scheduler side, master = sources/memory side.
interface memory_write_scheduler_if
  import mem_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);
  logic              hostValid;
  logic              hostReady;
  logic [ADDR_W-1:0] hostAddress;
  logic [DATA_W-1:0] hostData;
  logic              blitValid;
  logic              blitReady;
  logic [ADDR_W-1:0] blitAddress;
  logic [DATA_W-1:0] blitData;
  logic              memoryWriteRequest;
  logic [ADDR_W-1:0] memoryWriteAddress;
  logic [DATA_W-1:0] memoryWriteData;
  logic              memoryWriteComplete;

  modport slave (
    input  hostValid, hostAddress, hostData,
    input  blitValid, blitAddress, blitData,
    input  memoryWriteComplete,
    output hostReady, blitReady,
    output memoryWriteRequest, memoryWriteAddress, memoryWriteData
  );

  modport master (
    output hostValid, hostAddress, hostData,
    output blitValid, blitAddress, blitData,
    output memoryWriteComplete,
    input  hostReady, blitReady,
    input  memoryWriteRequest, memoryWriteAddress, memoryWriteData
  );
endinterface

// File: rtl/memory_write_scheduler_fifo.sv
// write_fifo: synchronous DEPTH-entry queue of write_entry_t; extra pointer bit distinguishes full from empty.
module write_fifo
  import mem_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  write_entry_t                 push_data,
  input  logic                         pop,
  output write_entry_t                 pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  write_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[PTR_W-2:0]] <= push_data;
        wr_ptr                 <= wr_ptr + PTR_W'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign pop_data = mem[rd_ptr[PTR_W-2:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign count    = wr_ptr - rd_ptr;
endmodule

// File: rtl/memory_write_scheduler.sv
// Arbitrates host/blitter writes into a FIFO and issues them over the MemoryManager request/complete handshake.
// Define MEMSCHED_HOST_PRIORITY_EN for fixed host priority instead of round-robin.
module memory_write_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  memory_write_scheduler_if.slave     bus,
  output logic [$clog2(DEPTH+1)-1:0]  queueCount,
  output logic                        idle
);
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         grant_host;
  logic         grant_blit;
  write_entry_t push_entry;
  write_entry_t head_entry;
  issue_state_t state;
  issue_state_t state_next;

`ifdef MEMSCHED_HOST_PRIORITY_EN
  always_comb begin
    grant_host = !full && bus.hostValid;
    grant_blit = !full && bus.blitValid && !bus.hostValid;
  end
`else
  requester_t rr_pointer;

  always_comb begin
    grant_host = !full && bus.hostValid && (!bus.blitValid || rr_pointer == REQ_HOST);
    grant_blit = !full && bus.blitValid && (!bus.hostValid || rr_pointer == REQ_BLIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_pointer <= REQ_HOST;
    end else if (grant_host) begin
      rr_pointer <= REQ_BLIT;
    end else if (grant_blit) begin
      rr_pointer <= REQ_HOST;
    end
  end
`endif

  always_comb begin
    push       = grant_host || grant_blit;
    push_entry = grant_host ? '{addr: bus.hostAddress, data: bus.hostData}
                            : '{addr: bus.blitAddress, data: bus.blitData};
  end

  assign bus.hostReady = grant_host;
  assign bus.blitReady = grant_blit;

  write_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (full),
    .empty     (empty),
    .count     (queueCount)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ISSUE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ISSUE_IDLE: if (!empty) state_next = ISSUE_WAIT;
      ISSUE_WAIT: if (bus.memoryWriteComplete) state_next = ISSUE_GAP;
      ISSUE_GAP:  state_next = ISSUE_IDLE;
      default:    state_next = ISSUE_IDLE;
    endcase
  end

  always_comb begin
    pop                    = (state == ISSUE_IDLE) && !empty;
    bus.memoryWriteRequest = (state == ISSUE_WAIT);
    idle                   = empty && (state != ISSUE_WAIT);
  end

  // Address/data are captured on the pop edge and only change at the next pop, so they stay stable through WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.memoryWriteAddress <= '0;
      bus.memoryWriteData    <= '0;
    end else if (pop) begin
      bus.memoryWriteAddress <= head_entry.addr;
      bus.memoryWriteData    <= head_entry.data;
    end
  end
endmodule

// File: tb/tb_memory_write_scheduler.sv
// Directed self-checking bench for memory_write_scheduler (round-robin or MEMSCHED_HOST_PRIORITY_EN build).
module tb_memory_write_scheduler;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] queueCount;
  logic       idle;
  int         total = 0;
  int         passes = 0;

  memory_write_scheduler_if bus ();

  memory_write_scheduler #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .queueCount (queueCount),
    .idle       (idle)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic serve_write(input string tag, input logic [16:0] exp_addr, input logic [7:0] exp_data);
    int n = 0;
    while (!bus.memoryWriteRequest && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_req"}, {31'd0, bus.memoryWriteRequest}, 32'd1);
    chk({tag, "_addr"}, {15'd0, bus.memoryWriteAddress}, {15'd0, exp_addr});
    chk({tag, "_data"}, {24'd0, bus.memoryWriteData}, {24'd0, exp_data});
    bus.memoryWriteComplete = 1'b1;
    cyc();
    bus.memoryWriteComplete = 1'b0;
    chk({tag, "_drop"}, {31'd0, bus.memoryWriteRequest}, 32'd0);
  endtask

  logic [16:0] h_addr [4];
  logic [7:0]  h_data [4];
  logic [16:0] b_addr [4];
  logic [7:0]  b_data [4];
  logic [16:0] e_addr [4];
  logic [7:0]  e_data [4];
  logic        e_host [4];

  initial begin
    int hi;
    int bi;
    bus.hostValid = 1'b0; bus.hostAddress = '0; bus.hostData = '0;
    bus.blitValid = 1'b0; bus.blitAddress = '0; bus.blitData = '0;
    bus.memoryWriteComplete = 1'b0;

    for (int i = 0; i < 4; i++) begin
      h_addr[i] = 17'h00100 + 17'(i);
      h_data[i] = 8'h10 + 8'(i);
      b_addr[i] = 17'h00200 + 17'(i);
      b_data[i] = 8'h20 + 8'(i);
    end
`ifdef MEMSCHED_HOST_PRIORITY_EN
    e_host = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin e_addr[i] = h_addr[i]; e_data[i] = h_data[i]; end
`else
    e_host = '{1'b1, 1'b0, 1'b1, 1'b0};
    e_addr = '{17'h00100, 17'h00200, 17'h00101, 17'h00201};
    e_data = '{8'h10, 8'h20, 8'h11, 8'h21};
`endif

    // Reset state
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_req", {31'd0, bus.memoryWriteRequest}, 32'd0);
    chk("rst_addr", {15'd0, bus.memoryWriteAddress}, 32'd0);
    chk("rst_data", {24'd0, bus.memoryWriteData}, 32'd0);
    chk("rst_count", {29'd0, queueCount}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_hready", {31'd0, bus.hostReady}, 32'd0);

    // 1: single host write, complete 3 cycles after request
    bus.hostValid = 1'b1; bus.hostAddress = 17'h1F000; bus.hostData = 8'hA5;
    #1;
    chk("t1_hready", {31'd0, bus.hostReady}, 32'd1);
    chk("t1_bready", {31'd0, bus.blitReady}, 32'd0);
    cyc();
    bus.hostValid = 1'b0;
    chk("t1_count1", {29'd0, queueCount}, 32'd1);
    chk("t1_noreq", {31'd0, bus.memoryWriteRequest}, 32'd0);
    chk("t1_busy", {31'd0, idle}, 32'd0);
    cyc();
    chk("t1_req", {31'd0, bus.memoryWriteRequest}, 32'd1);
    chk("t1_count0", {29'd0, queueCount}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_hold_req", {31'd0, bus.memoryWriteRequest}, 32'd1);
      chk("t1_hold_addr", {15'd0, bus.memoryWriteAddress}, 32'h1F000);
      chk("t1_hold_data", {24'd0, bus.memoryWriteData}, 32'hA5);
      chk("t1_busy_wait", {31'd0, idle}, 32'd0);
      if (i < 2) cyc();
    end
    bus.memoryWriteComplete = 1'b1;
    cyc();
    bus.memoryWriteComplete = 1'b0;
    chk("t1_gap", {31'd0, bus.memoryWriteRequest}, 32'd0);
    cyc();
    chk("t1_gap_done", {31'd0, bus.memoryWriteRequest}, 32'd0);
    chk("t1_idle", {31'd0, idle}, 32'd1);

    // 2/3: both sources valid for 4 cycles
    reset = 1'b1; cyc(); reset = 1'b0;
    hi = 0; bi = 0;
    bus.hostValid = 1'b1; bus.blitValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.hostAddress = h_addr[hi]; bus.hostData = h_data[hi];
      bus.blitAddress = b_addr[bi]; bus.blitData = b_data[bi];
      #1;
      chk("t2_hready", {31'd0, bus.hostReady}, {31'd0, e_host[c]});
      chk("t2_bready", {31'd0, bus.blitReady}, {31'd0, !e_host[c]});
      cyc();
      if (e_host[c]) hi++; else bi++;
    end
    bus.hostValid = 1'b0; bus.blitValid = 1'b0;
    for (int w = 0; w < 4; w++) serve_write("t2_issue", e_addr[w], e_data[w]);
    cyc(); cyc();
    chk("t2_idle", {31'd0, idle}, 32'd1);
    chk("t2_count", {29'd0, queueCount}, 32'd0);

    // 4: fill FIFO with complete held low
    reset = 1'b1; cyc(); reset = 1'b0;
    bus.hostValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.hostAddress = 17'h00300 + 17'(c); bus.hostData = 8'h30 + 8'(c);
      #1;
      chk("t4_accept", {31'd0, bus.hostReady}, 32'd1);
      cyc();
    end
    bus.blitValid = 1'b1;
    #1;
    chk("t4_count_full", {29'd0, queueCount}, 32'd4);
    chk("t4_hready_full", {31'd0, bus.hostReady}, 32'd0);
    chk("t4_bready_full", {31'd0, bus.blitReady}, 32'd0);
    chk("t4_req", {31'd0, bus.memoryWriteRequest}, 32'd1);
    chk("t4_addr", {15'd0, bus.memoryWriteAddress}, 32'h00300);
    bus.blitValid = 1'b0;
    bus.memoryWriteComplete = 1'b1;
    cyc();
    bus.memoryWriteComplete = 1'b0;
    chk("t4_gap_full", {31'd0, bus.hostReady}, 32'd0);
    cyc();
    chk("t4_idle_full", {31'd0, bus.hostReady}, 32'd0);
    cyc();
    chk("t4_count_pop", {29'd0, queueCount}, 32'd3);
    chk("t4_ready_after_pop", {31'd0, bus.hostReady}, 32'd1);
    chk("t4_next_addr", {15'd0, bus.memoryWriteAddress}, 32'h00301);
    bus.hostValid = 1'b0;
    #1;

    // 5: reset during WAIT with 3 queued
    chk("t5_pre_count", {29'd0, queueCount}, 32'd3);
    chk("t5_pre_req", {31'd0, bus.memoryWriteRequest}, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_req", {31'd0, bus.memoryWriteRequest}, 32'd0);
    chk("t5_count", {29'd0, queueCount}, 32'd0);
    chk("t5_idle", {31'd0, idle}, 32'd1);
    for (int c = 0; c < 5; c++) cyc();
    chk("t5_no_issue", {31'd0, bus.memoryWriteRequest}, 32'd0);
    chk("t5_still_idle", {31'd0, idle}, 32'd1);

    // 6: spurious complete while idle, then while a pop is happening
    bus.memoryWriteComplete = 1'b1;
    cyc();
    bus.memoryWriteComplete = 1'b0;
    chk("t6_idle", {31'd0, idle}, 32'd1);
    chk("t6_count", {29'd0, queueCount}, 32'd0);
    chk("t6_req", {31'd0, bus.memoryWriteRequest}, 32'd0);
    bus.blitValid = 1'b1; bus.blitAddress = 17'h0ABCD; bus.blitData = 8'h5A;
    cyc();
    bus.blitValid = 1'b0;
    bus.memoryWriteComplete = 1'b1;
    cyc();
    bus.memoryWriteComplete = 1'b0;
    chk("t6_req_issued", {31'd0, bus.memoryWriteRequest}, 32'd1);
    cyc();
    chk("t6_req_held", {31'd0, bus.memoryWriteRequest}, 32'd1);
    chk("t6_addr", {15'd0, bus.memoryWriteAddress}, 32'h0ABCD);
    chk("t6_data", {24'd0, bus.memoryWriteData}, 32'h5A);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
